pea_scheduler: RTL and testbench
================================

PEA_SCHEDULER -- requirements
Module: pea_scheduler

Interface
REQ-001 Parameter TIMEOUT, default 255, is the maximum number of cycles to wait for FC after invoke before flagging an error.
REQ-002 Parameter CNT_W, default 16, is the width of the firing counter.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 run  input  1  level; while high the scheduler fires the actor whenever it is enabled.
REQ-006 clr_err  input  1  single-cycle pulse; clears a sticky error.
REQ-007 enable  input  1  combinational fireability from PEA_enable, evaluated for the current next_instr.
REQ-008 FC  input  1  firing-complete from PEA_top_module_1.
REQ-009 instr  input  8  opcode of the firing just completed, valid while FC is high.
REQ-010 invoke  output  1  one-cycle firing request to PEA_top_module_1.
REQ-011 next_instr  output  2  CFDF mode presented to the actor and to PEA_enable.
REQ-012 busy  output  1  high from the invoke cycle through FC acceptance.
REQ-013 err  output  1  sticky timeout flag.
REQ-014 fire_count  output  CNT_W  number of completed firings.

Function
REQ-015 FSM states: IDLE, SETTLE, INVOKE, WAIT_FC, ADVANCE, ERROR.
REQ-016 IDLE transitions:
  - run=1 -> SETTLE.
  - otherwise stays in IDLE.
REQ-017 SETTLE lasts one cycle so that enable reflects the current next_instr.
  - enable=1 and run=1 -> INVOKE.
  - run=0 -> IDLE.
  - otherwise stays in SETTLE.
REQ-018 INVOKE lasts exactly one cycle with invoke=1, then moves to WAIT_FC; invoke is 0 in every other state.
REQ-019 FC is ignored during the INVOKE cycle and is accepted from the first WAIT_FC cycle onward.
REQ-020 WAIT_FC behaviour:
  - FC=1 -> ADVANCE; instr is captured and fire_count increments (wraps modulo 2^CNT_W).
  - A wait counter counts cycles in WAIT_FC; reaching TIMEOUT with FC=0 -> ERROR.
REQ-021 ADVANCE lasts one cycle and updates next_instr from the captured opcode:
  - SETUP_INSTR -> INSTR.
  - INSTR with opcode OPC_EVP -> OUTPUT.
  - INSTR with opcode OPC_RST -> SETUP_INSTR.
  - INSTR with any other opcode -> INSTR.
  - OUTPUT -> INSTR.
  Then -> SETTLE.
REQ-022 ERROR holds err=1, busy=0, invoke=0.
  - clr_err=1 -> IDLE with err=0; next_instr is unchanged.
REQ-023 busy=1 exactly in INVOKE and WAIT_FC.
REQ-024 Dropping run mid-firing does not abort it; the firing completes through ADVANCE, and SETTLE then returns to IDLE.
REQ-025 If run and enable are both high in every SETTLE, the maximum firing throughput is one invoke per 3 cycles plus FC latency.
REQ-026 clr_err outside ERROR is ignored; FC outside WAIT_FC is ignored and does not increment fire_count.

Reset
REQ-027 When rst=1 at a clock edge:
  - state <- IDLE.
  - next_instr <- SETUP_INSTR.
  - invoke, busy, err <- 0.
  - fire_count, wait counter, captured opcode <- 0.
REQ-028 Reset overrides every other input in the same cycle, including mid-firing.

Structure
REQ-029 Package pea_pkg holds:
  - mode constants SETUP_INSTR=2'b00, INSTR=2'b01, OUTPUT=2'b10;
  - opcode constants OPC_RST=8'h00, OPC_EVP=8'h03;
  - the FSM state encoding.
REQ-030 The wait counter is the sub-module pea_wdog, with ports clk, rst, clear, count_en, TIMEOUT parameter and an expired output.

Verification
REQ-031 Reset then run=1, enable=1, FC returned 4 cycles after invoke, instr=8'h01 -> one invoke pulse; next_instr goes 00->01; fire_count=1.
REQ-032 In INSTR mode, FC with instr=OPC_EVP -> next_instr=10; the next completed firing -> next_instr=01; fire_count advances by 2.
REQ-033 TIMEOUT=8, FC held low -> err=1 exactly 8 WAIT_FC cycles after invoke, invoke stays 0; clr_err -> err=0, state IDLE.
REQ-034 FC held high during the INVOKE cycle and deasserted next cycle -> not accepted; the scheduler stays in WAIT_FC and fire_count is unchanged.
REQ-035 rst asserted during WAIT_FC -> next cycle: next_instr=00, busy=0, fire_count=0; a later FC is ignored.
REQ-036 enable=0 with run=1 -> no invoke for 50 cycles; raising enable -> invoke exactly one cycle later.

Source files
------------

// File: rtl/pea_pkg.sv
// rtl/pea_pkg.sv - shared constants and FSM encoding for the PEA scheduler
// Purpose: CFDF mode constants, actor opcodes and the scheduler state type.
// Ports:   none (package).
package pea_pkg;

  // CFDF modes presented on next_instr
  localparam logic [1:0] SETUP_INSTR = 2'b00;
  localparam logic [1:0] INSTR       = 2'b01;
  localparam logic [1:0] OUTPUT      = 2'b10;

  // Opcodes reported by the actor on completion
  localparam logic [7:0] OPC_RST = 8'h00;
  localparam logic [7:0] OPC_EVP = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_INVOKE  = 3'd2,
    ST_WAIT_FC = 3'd3,
    ST_ADVANCE = 3'd4,
    ST_ERROR   = 3'd5
  } state_t;

  // Mode sequencing applied in ADVANCE from the captured opcode.
  function automatic logic [1:0] next_mode(input logic [1:0] mode, input logic [7:0] opc);
    logic [1:0] m;
    m = SETUP_INSTR;
    case (mode)
      SETUP_INSTR: m = INSTR;
      INSTR: begin
        if (opc == OPC_EVP)      m = OUTPUT;
        else if (opc == OPC_RST) m = SETUP_INSTR;
        else                     m = INSTR;
      end
      OUTPUT:  m = INSTR;
      default: m = SETUP_INSTR;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/pea_wdog.sv
// rtl/pea_wdog.sv - firing-complete watchdog counter
// Purpose: counts enabled cycles since the last clear and flags when the
//          current counted cycle is the TIMEOUT-th one.
// Ports:   clk, rst (sync, active-high), clear (restart count),
//          count_en (count this cycle), expired (TIMEOUT-th counted cycle).
module pea_wdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt;

  // cnt holds the number of counted cycles already completed, so the
  // TIMEOUT-th counted cycle is the one where cnt equals TIMEOUT-1.
  assign expired = count_en && (cnt == W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (count_en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pea_scheduler.sv
// rtl/pea_scheduler.sv - CFDF actor firing scheduler with FC watchdog
// Purpose: fires the actor when enabled while run is high, tracks the CFDF
//          mode from completed opcodes and flags a sticky FC timeout.
// Ports:   clk, rst (sync, active-high), run, clr_err, enable, FC, instr[7:0]
//          in; invoke, next_instr[1:0], busy, err, fire_count[CNT_W-1:0] out.
module pea_scheduler
  import pea_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clr_err,
  input  logic             enable,
  input  logic             FC,
  input  logic [7:0]       instr,
  output logic             invoke,
  output logic [1:0]       next_instr,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] fire_count
);

  state_t     state, state_nxt;
  logic [7:0] opc_q;
  logic       expired;
  logic       fc_accept;

  // FC only counts in WAIT_FC; the INVOKE cycle never samples it.
  assign fc_accept = (state == ST_WAIT_FC) && FC;

  pea_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .clear    (state != ST_WAIT_FC),
    .count_en (state == ST_WAIT_FC),
    .expired  (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    invoke    = 1'b0;
    busy      = 1'b0;
    err       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (run) state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!run)        state_nxt = ST_IDLE;
        else if (enable) state_nxt = ST_INVOKE;
      end
      ST_INVOKE: begin
        invoke    = 1'b1;
        busy      = 1'b1;
        state_nxt = ST_WAIT_FC;
      end
      ST_WAIT_FC: begin
        busy = 1'b1;
        // A completion in the last allowed cycle still wins over the timeout.
        if (FC)           state_nxt = ST_ADVANCE;
        else if (expired) state_nxt = ST_ERROR;
      end
      ST_ADVANCE: begin
        state_nxt = ST_SETTLE;
      end
      ST_ERROR: begin
        err = 1'b1;
        if (clr_err) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opc_q      <= '0;
      fire_count <= '0;
      next_instr <= SETUP_INSTR;
    end else begin
      if (fc_accept) begin
        opc_q      <= instr;
        fire_count <= fire_count + 1'b1;
      end
      if (state == ST_ADVANCE) begin
        next_instr <= next_mode(next_instr, opc_q);
      end
    end
  end

endmodule

// File: tb/tb_pea_scheduler.sv
// tb/tb_pea_scheduler.sv - directed self-checking bench for pea_scheduler
module tb_pea_scheduler;

  logic        clk = 1'b0;
  logic        rst, run, clr_err, enable, FC;
  logic [7:0]  instr;
  logic        invoke, busy, err;
  logic [1:0]  next_instr;
  logic [15:0] fire_count;

  int checks = 0;
  int errors = 0;
  int inv_seen;

  pea_scheduler #(.TIMEOUT(8), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .clr_err    (clr_err),
    .enable     (enable),
    .FC         (FC),
    .instr      (instr),
    .invoke     (invoke),
    .next_instr (next_instr),
    .busy       (busy),
    .err        (err),
    .fire_count (fire_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; clr_err = 1'b0; enable = 1'b0; FC = 1'b0; instr = 8'h00;
    tick();
    tick();
    chk("rst_invoke", 32'(invoke), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_mode", 32'(next_instr), 32'd0);
    chk("rst_count", 32'(fire_count), 32'd0);

    // first firing: SETUP_INSTR -> INSTR, FC 4 cycles after invoke
    rst = 1'b0; run = 1'b1; enable = 1'b1;
    tick();                                   // SETTLE
    chk("settle_no_invoke", 32'(invoke), 32'd0);
    tick();                                   // INVOKE
    chk("invoke_pulse", 32'(invoke), 32'd1);
    chk("invoke_busy", 32'(busy), 32'd1);
    tick();                                   // WAIT_FC 1
    chk("wait_invoke_low", 32'(invoke), 32'd0);
    chk("wait_busy", 32'(busy), 32'd1);
    tick();
    tick();                                   // WAIT_FC 3
    FC = 1'b1; instr = 8'h01;
    tick();                                   // ADVANCE
    FC = 1'b0;
    chk("f1_count", 32'(fire_count), 32'd1);
    chk("adv_busy", 32'(busy), 32'd0);
    chk("adv_mode_old", 32'(next_instr), 32'd0);
    tick();                                   // SETTLE
    chk("f1_mode", 32'(next_instr), 32'd1);

    // INSTR + EVP -> OUTPUT, then OUTPUT -> INSTR
    tick();                                   // INVOKE
    chk("f2_invoke", 32'(invoke), 32'd1);
    tick();                                   // WAIT_FC
    FC = 1'b1; instr = 8'h03;
    tick();                                   // ADVANCE
    FC = 1'b0;
    chk("f2_count", 32'(fire_count), 32'd2);
    tick();
    chk("f2_mode_output", 32'(next_instr), 32'd2);
    tick();                                   // INVOKE
    tick();                                   // WAIT_FC
    FC = 1'b1; instr = 8'h55;
    tick();
    FC = 1'b0;
    chk("f3_count", 32'(fire_count), 32'd3);
    tick();                                   // SETTLE
    chk("f3_mode_instr", 32'(next_instr), 32'd1);

    // FC high only during INVOKE is not accepted
    tick();                                   // INVOKE
    FC = 1'b1; instr = 8'h00;
    tick();                                   // WAIT_FC (FC ignored)
    FC = 1'b0;
    tick();
    chk("fc_in_invoke_busy", 32'(busy), 32'd1);
    chk("fc_in_invoke_count", 32'(fire_count), 32'd3);
    FC = 1'b1;                                // OPC_RST from INSTR
    tick();                                   // ADVANCE
    FC = 1'b0; run = 1'b0;                    // run drop does not abort
    chk("f4_count", 32'(fire_count), 32'd4);
    tick();                                   // SETTLE
    chk("f4_mode_setup", 32'(next_instr), 32'd0);
    tick();                                   // IDLE
    chk("idle_busy", 32'(busy), 32'd0);

    // FC outside WAIT_FC is ignored
    FC = 1'b1; instr = 8'h01;
    tick(); tick(); tick();
    FC = 1'b0;
    chk("fc_idle_count", 32'(fire_count), 32'd4);

    // enable low holds off invoke; raising it invokes one cycle later
    run = 1'b1; enable = 1'b0;
    tick();                                   // SETTLE
    inv_seen = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (invoke) inv_seen++;
    end
    chk("no_invoke_disabled", 32'(inv_seen), 32'd0);
    enable = 1'b1;
    tick();
    chk("invoke_after_enable", 32'(invoke), 32'd1);

    // timeout: 8 WAIT_FC cycles then ERROR
    enable = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("to_wait8_err", 32'(err), 32'd0);
    chk("to_wait8_busy", 32'(busy), 32'd1);
    tick();
    chk("to_err", 32'(err), 32'd1);
    chk("to_err_busy", 32'(busy), 32'd0);
    inv_seen = 0;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (invoke) inv_seen++;
    end
    chk("to_no_invoke", 32'(inv_seen), 32'd0);
    chk("to_err_sticky", 32'(err), 32'd1);
    clr_err = 1'b1; run = 1'b0;
    tick();
    clr_err = 1'b0;
    chk("clr_err", 32'(err), 32'd0);
    chk("clr_mode_kept", 32'(next_instr), 32'd0);
    run = 1'b1; enable = 1'b1;
    tick();                                   // IDLE -> SETTLE
    chk("clr_idle_settle", 32'(invoke), 32'd0);
    tick();
    chk("clr_idle_invoke", 32'(invoke), 32'd1);

    // reset during WAIT_FC while in INSTR mode
    tick();                                   // WAIT_FC
    FC = 1'b1; instr = 8'h01;
    tick();                                   // ADVANCE
    FC = 1'b0;
    chk("f5_count", 32'(fire_count), 32'd5);
    tick();                                   // SETTLE
    chk("f5_mode", 32'(next_instr), 32'd1);
    tick();                                   // INVOKE
    tick();                                   // WAIT_FC
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1; FC = 1'b1;
    tick();
    rst = 1'b0; run = 1'b0;
    chk("mid_rst_mode", 32'(next_instr), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_count", 32'(fire_count), 32'd0);
    tick(); tick();
    FC = 1'b0;
    chk("post_rst_fc_ignored", 32'(fire_count), 32'd0);
    chk("post_rst_err", 32'(err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
